// File: rtl/i2c_cfg_sequencer.sv
// i2c_cfg_sequencer
//   Walks a combinational sensor-config LUT from index 0 to lut_size-1. Each
//   24-bit word {reg_addr, reg_data} goes to the I2C write master, one word
//   at a time. Also provides a power-on delay, an idle gap between writes,
//   bounded retry on NACK, and done/error status.
//
// Ports
//   clk          system clock
//   rst_n        asynchronous active-low reset
//   restart      1-cycle pulse, reruns the whole sequence (only in DONE/FAIL)
//   lut_index    index presented to the config LUT
//   lut_data     LUT word for lut_index (combinational)
//   lut_size     number of LUT entries, looked at in LOAD
//   i2c_req      level write request, held until i2c_done
//   i2c_wdata    word being written, stable while i2c_req=1
//   i2c_done     1-cycle completion pulse from the master
//   i2c_ack_err  qualifies i2c_done: 1 = slave NACK
//   busy         1 in every state except DONE and FAIL
//   config_done  1 in DONE
//   config_error 1 in FAIL
//   err_index    entry that exhausted its retries, valid while config_error=1
module i2c_cfg_sequencer #(
  parameter logic [19:0] POWERON_DELAY = 20'd1_000_000,
  parameter logic [15:0] GAP_CYCLES    = 16'd1000,
  parameter logic [3:0]  MAX_RETRY     = 4'd3
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        restart,
  output logic [7:0]  lut_index,
  input  logic [23:0] lut_data,
  input  logic [7:0]  lut_size,
  output logic        i2c_req,
  output logic [23:0] i2c_wdata,
  input  logic        i2c_done,
  input  logic        i2c_ack_err,
  output logic        busy,
  output logic        config_done,
  output logic        config_error,
  output logic [7:0]  err_index
);

  typedef enum logic [2:0] {
    PWR_WAIT,
    LOAD,
    WAIT,
    GAP,
    DONE,
    FAIL
  } state_t;

  state_t      state, state_nxt;
  logic [19:0] delay_cnt, delay_cnt_nxt;
  logic [15:0] gap_cnt, gap_cnt_nxt;
  logic [7:0]  index_nxt;
  logic [3:0]  retry, retry_nxt;
  logic        req_nxt;
  logic [23:0] wdata_nxt;
  logic [7:0]  err_index_nxt;
  logic        delay_expired;
  logic        gap_expired;

  // A zero-length delay or gap must still leave its state after one cycle,
  // so the "last count" compare cannot rely on PARAM-1 (it would wrap).
  assign delay_expired = (POWERON_DELAY == 20'd0) || (delay_cnt == POWERON_DELAY - 20'd1);
  assign gap_expired   = (GAP_CYCLES == 16'd0) || (gap_cnt == GAP_CYCLES - 16'd1);

  assign busy         = (state != DONE) && (state != FAIL);
  assign config_done  = (state == DONE);
  assign config_error = (state == FAIL);

  // State and datapath registers. Reset also drops i2c_req at once, so an
  // aborted transfer never leaves a request hanging.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= PWR_WAIT;
      delay_cnt <= '0;
      gap_cnt   <= '0;
      lut_index <= '0;
      retry     <= '0;
      i2c_req   <= 1'b0;
      i2c_wdata <= '0;
      err_index <= '0;
    end else begin
      state     <= state_nxt;
      delay_cnt <= delay_cnt_nxt;
      gap_cnt   <= gap_cnt_nxt;
      lut_index <= index_nxt;
      retry     <= retry_nxt;
      i2c_req   <= req_nxt;
      i2c_wdata <= wdata_nxt;
      err_index <= err_index_nxt;
    end
  end

  // Next-state and next-value logic. Every register holds by default.
  // i2c_done is only looked at in WAIT, and restart only in DONE/FAIL.
  always_comb begin
    state_nxt     = state;
    delay_cnt_nxt = delay_cnt;
    gap_cnt_nxt   = gap_cnt;
    index_nxt     = lut_index;
    retry_nxt     = retry;
    req_nxt       = i2c_req;
    wdata_nxt     = i2c_wdata;
    err_index_nxt = err_index;

    case (state)
      PWR_WAIT: begin
        if (delay_expired) begin
          delay_cnt_nxt = '0;
          state_nxt     = LOAD;
        end else begin
          delay_cnt_nxt = delay_cnt + 20'd1;
        end
      end

      LOAD: begin
        // The >= compare also covers an empty LUT: no write is ever issued.
        if (lut_index >= lut_size) begin
          state_nxt = DONE;
        end else begin
          wdata_nxt = lut_data;
          req_nxt   = 1'b1;
          state_nxt = WAIT;
        end
      end

      WAIT: begin
        if (i2c_done) begin
          req_nxt     = 1'b0;
          gap_cnt_nxt = '0;
          if (!i2c_ack_err) begin
            index_nxt = lut_index + 8'd1;
            retry_nxt = '0;
            state_nxt = GAP;
          end else if (retry < MAX_RETRY) begin
            retry_nxt = retry + 4'd1;
            state_nxt = GAP;
          end else begin
            err_index_nxt = lut_index;
            state_nxt     = FAIL;
          end
        end
      end

      GAP: begin
        if (gap_expired) begin
          gap_cnt_nxt = '0;
          state_nxt   = LOAD;
        end else begin
          gap_cnt_nxt = gap_cnt + 16'd1;
        end
      end

      DONE, FAIL: begin
        if (restart) begin
          state_nxt     = PWR_WAIT;
          delay_cnt_nxt = '0;
          gap_cnt_nxt   = '0;
          index_nxt     = '0;
          retry_nxt     = '0;
          err_index_nxt = '0;
        end
      end

      default: begin
        state_nxt = PWR_WAIT;
      end
    endcase
  end

endmodule

// File: tb/tb_i2c_cfg_sequencer.sv
// tb_i2c_cfg_sequencer
//   Directed bench for i2c_cfg_sequencer. It uses a behavioural I2C master
//   with programmable latency and a NACK plan. Expected request words are
//   queued when a run is set up and checked off as requests appear.
//   Ports: none (top-level bench).
module tb_i2c_cfg_sequencer;

  localparam int PD  = 8;
  localparam int GAP = 2;
  localparam int MR  = 2;

  typedef struct packed {
    logic [7:0]  idx;
    logic [23:0] word;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        restart = 1'b0;
  logic [7:0]  lut_index;
  logic [23:0] lut_data;
  logic [7:0]  lut_size = 8'd10;
  logic        i2c_req;
  logic [23:0] i2c_wdata;
  logic        i2c_done = 1'b0;
  logic        i2c_ack_err = 1'b0;
  logic        busy;
  logic        config_done;
  logic        config_error;
  logic [7:0]  err_index;

  int   checks = 0;
  int   failures = 0;
  int   cycle = 0;
  int   req_count = 0;
  int   rise_q[$];
  exp_t exp_q[$];

  int   latency = 1;
  int   nack_index = -1;
  int   nack_limit = 0;
  int   nacks_given = 0;

  i2c_cfg_sequencer #(
    .POWERON_DELAY(20'(PD)),
    .GAP_CYCLES   (16'(GAP)),
    .MAX_RETRY    (4'(MR))
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .restart     (restart),
    .lut_index   (lut_index),
    .lut_data    (lut_data),
    .lut_size    (lut_size),
    .i2c_req     (i2c_req),
    .i2c_wdata   (i2c_wdata),
    .i2c_done    (i2c_done),
    .i2c_ack_err (i2c_ack_err),
    .busy        (busy),
    .config_done (config_done),
    .config_error(config_error),
    .err_index   (err_index)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cycle <= cycle + 1;

  // Bench config LUT: entry 0 is a distinctive word, others are {i, i, FF}.
  function automatic logic [23:0] lut_word(input logic [7:0] i);
    if (i == 8'd0) return 24'h0D0001;
    return {i, i, 8'hFF};
  endfunction

  assign lut_data = lut_word(lut_index);

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  // Queue the expected request stream for a run and program the NACK plan.
  task automatic applyStimulus(input int size, input int nack_idx, input int nack_times);
    exp_t e;
    nack_index  = nack_idx;
    nack_limit  = nack_times;
    nacks_given = 0;
    for (int i = 0; i < size; i++) begin
      int attempts;
      attempts = 1;
      if (i == nack_idx) attempts = (nack_times > MR) ? MR + 1 : nack_times + 1;
      for (int a = 0; a < attempts; a++) begin
        e.idx  = 8'(i);
        e.word = lut_word(8'(i));
        exp_q.push_back(e);
      end
      if (i == nack_idx && nack_times > MR) break;
    end
  endtask

  task automatic pulseRestart();
    @(negedge clk);
    restart = 1'b1;
    @(negedge clk);
    restart = 1'b0;
  endtask

  task automatic waitEnd(input string tag, input int budget);
    int n;
    n = 0;
    while (!(config_done || config_error) && n < budget) begin
      @(negedge clk);
      n++;
    end
    checkOutput({tag, "_timeout"}, 32'(n >= budget), 32'd0);
  endtask

  task automatic waitIdxReq(input string tag, input logic [7:0] idx, input int budget);
    int n;
    n = 0;
    while (!(i2c_req && lut_index == idx) && n < budget) begin
      @(negedge clk);
      n++;
    end
    checkOutput({tag, "_timeout"}, 32'(n >= budget), 32'd0);
  endtask

  // Behavioural master: completes each request `latency` cycles after it is seen.
  task automatic runMaster();
    bit active;
    int cnt;
    active = 1'b0;
    cnt = 0;
    forever begin
      @(negedge clk);
      i2c_done    = 1'b0;
      i2c_ack_err = 1'b0;
      if (!rst_n) begin
        active = 1'b0;
      end else if (active) begin
        cnt++;
        if (cnt >= latency) begin
          i2c_done = 1'b1;
          active   = 1'b0;
          if (int'(lut_index) == nack_index && nacks_given < nack_limit) begin
            i2c_ack_err = 1'b1;
            nacks_given++;
          end
        end
      end else if (i2c_req) begin
        active = 1'b1;
        cnt    = 0;
      end
    end
  endtask

  // Scoreboard side: each rising i2c_req pops one expected entry.
  task automatic runMonitor();
    logic        prev_req;
    logic [23:0] held;
    exp_t        e;
    prev_req = 1'b0;
    held     = '0;
    forever begin
      @(negedge clk);
      if (i2c_req && !prev_req) begin
        req_count++;
        rise_q.push_back(cycle);
        if (exp_q.size() == 0) begin
          checkOutput("unexpected_req", 32'(exp_q.size()), 32'd1);
        end else begin
          e = exp_q.pop_front();
          checkOutput("req_wdata", {8'h0, i2c_wdata}, {8'h0, e.word});
          checkOutput("req_index", {24'h0, lut_index}, {24'h0, e.idx});
        end
      end else if (i2c_req && prev_req) begin
        checkOutput("wdata_stable", {8'h0, i2c_wdata}, {8'h0, held});
      end
      prev_req = i2c_req;
      held     = i2c_wdata;
    end
  endtask

  initial begin
    int rel;
    int base_rise;
    int base_req;
    int n;

    fork
      runMaster();
      runMonitor();
    join_none

    // Reset values
    repeat (3) @(negedge clk);
    checkOutput("rst_req",       32'(i2c_req),      32'd0);
    checkOutput("rst_busy",      32'(busy),         32'd1);
    checkOutput("rst_done",      32'(config_done),  32'd0);
    checkOutput("rst_error",     32'(config_error), 32'd0);
    checkOutput("rst_index",     32'(lut_index),    32'd0);
    checkOutput("rst_err_index", 32'(err_index),    32'd0);
    checkOutput("rst_wdata",     32'(i2c_wdata),    32'd0);

    // 1: plain run, all acked, first request PD+1 cycles after release
    $display("[TB] test 1: full sequence, all acked");
    latency   = 1;
    base_rise = rise_q.size();
    base_req  = req_count;
    applyStimulus(10, -1, 0);
    @(negedge clk);
    rst_n = 1'b1;
    rel   = cycle;
    waitEnd("t1", 400);
    checkOutput("t1_first_req_clk", 32'(rise_q[base_rise] - rel), 32'(PD + 1));
    checkOutput("t1_req_count",     32'(req_count - base_req),    32'd10);
    checkOutput("t1_queue_empty",   32'(exp_q.size()),            32'd0);
    checkOutput("t1_done",          32'(config_done),             32'd1);
    checkOutput("t1_busy",          32'(busy),                    32'd0);
    checkOutput("t1_error",         32'(config_error),            32'd0);

    // 2: slow master, request spacing = latency + done + gap + load
    $display("[TB] test 2: request spacing with 5-cycle master");
    latency   = 5;
    base_rise = rise_q.size();
    applyStimulus(10, -1, 0);
    pulseRestart();
    checkOutput("t2_done_cleared", 32'(config_done), 32'd0);
    waitEnd("t2", 600);
    checkOutput("t2_req_count", 32'(rise_q.size() - base_rise), 32'd10);
    for (int i = base_rise + 1; i < rise_q.size(); i++)
      checkOutput("t2_spacing", 32'(rise_q[i] - rise_q[i-1]), 32'(latency + 1 + GAP + 1));
    checkOutput("t2_done", 32'(config_done), 32'd1);

    // 3: two NACKs on entry 4, then ack
    $display("[TB] test 3: retry recovers");
    latency  = 2;
    base_req = req_count;
    applyStimulus(10, 4, 2);
    pulseRestart();
    waitEnd("t3", 600);
    checkOutput("t3_req_count",   32'(req_count - base_req), 32'd12);
    checkOutput("t3_queue_empty", 32'(exp_q.size()),         32'd0);
    checkOutput("t3_done",        32'(config_done),          32'd1);
    checkOutput("t3_error",       32'(config_error),         32'd0);

    // 4: entry 7 always NACKs, retries exhausted
    $display("[TB] test 4: retry exhaustion");
    base_req = req_count;
    applyStimulus(10, 7, 255);
    pulseRestart();
    waitEnd("t4", 600);
    repeat (20) @(negedge clk);
    checkOutput("t4_error",       32'(config_error),         32'd1);
    checkOutput("t4_err_index",   32'(err_index),            32'd7);
    checkOutput("t4_busy",        32'(busy),                 32'd0);
    checkOutput("t4_done",        32'(config_done),          32'd0);
    checkOutput("t4_req_count",   32'(req_count - base_req), 32'd10);
    checkOutput("t4_queue_empty", 32'(exp_q.size()),         32'd0);
    checkOutput("t4_req_low",     32'(i2c_req),              32'd0);
    applyStimulus(10, -1, 0);
    pulseRestart();
    checkOutput("t4_error_cleared", 32'(config_error), 32'd0);
    checkOutput("t4_busy_again",    32'(busy),         32'd1);
    waitEnd("t4_rerun", 600);
    checkOutput("t4_rerun_done",    32'(config_done),  32'd1);
    checkOutput("t4_rerun_empty",   32'(exp_q.size()), 32'd0);

    // 5: empty LUT
    $display("[TB] test 5: lut_size = 0");
    lut_size = 8'd0;
    base_req = req_count;
    applyStimulus(0, -1, 0);
    pulseRestart();
    rel = cycle;
    checkOutput("t5_busy_start", 32'(busy),        32'd1);
    checkOutput("t5_done_start", 32'(config_done), 32'd0);
    n = 0;
    while (!config_done && n < 100) begin
      @(negedge clk);
      n++;
    end
    checkOutput("t5_done_clk",   32'(cycle - rel),          32'(PD + 1));
    checkOutput("t5_no_req",     32'(req_count - base_req), 32'd0);
    lut_size = 8'd10;

    // 6: reset mid-transfer at entry 5; restart pulses while busy are ignored
    $display("[TB] test 6: reset mid-transfer");
    latency = 30;
    applyStimulus(10, -1, 0);
    pulseRestart();
    waitIdxReq("t6_idx2", 8'd2, 400);
    pulseRestart();
    checkOutput("t6_busy_after_restart", 32'(busy),        32'd1);
    checkOutput("t6_req_after_restart",  32'(i2c_req),     32'd1);
    checkOutput("t6_idx_after_restart",  32'(lut_index),   32'd2);
    waitIdxReq("t6_idx5", 8'd5, 400);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checkOutput("t6_req_async_drop", 32'(i2c_req),   32'd0);
    checkOutput("t6_index_cleared",  32'(lut_index), 32'd0);
    checkOutput("t6_busy_in_reset",  32'(busy),      32'd1);
    exp_q.delete();
    repeat (2) @(negedge clk);
    latency   = 3;
    base_rise = rise_q.size();
    applyStimulus(10, -1, 0);
    rst_n = 1'b1;
    rel   = cycle;
    pulseRestart();
    waitIdxReq("t6_rerun_idx2", 8'd2, 400);
    pulseRestart();
    waitEnd("t6", 600);
    checkOutput("t6_first_req_clk", 32'(rise_q[base_rise] - rel), 32'(PD + 1));
    checkOutput("t6_req_count",     32'(rise_q.size() - base_rise), 32'd10);
    checkOutput("t6_queue_empty",   32'(exp_q.size()),            32'd0);
    checkOutput("t6_done",          32'(config_done),             32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
